// File: rtl/matrix_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_controller_if
// Description : Request/stream bundle between a scan client and the
//               matrix scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_scan_controller_if #(
    parameter int M     = 3,
    parameter int N     = 2,
    parameter int nBits = 8
);
    logic                   start;
    logic                   mode;
    logic                   abort;
    logic [M*N*nBits-1:0]   matrix;
    logic                   out_ready;
    logic                   out_valid;
    logic [nBits-1:0]       element;
    logic [nBits-1:0]       ipos;
    logic [nBits-1:0]       jpos;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    modport master (
        output start, mode, abort, matrix, out_ready,
        input  out_valid, element, ipos, jpos, out_last, busy, done
    );

    modport slave (
        input  start, mode, abort, matrix, out_ready,
        output out_valid, element, ipos, jpos, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_controller
// Description : Streams a latched MxN matrix element by element in row- or
//               column-major order over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_controller #(
    parameter int M     = 3,
    parameter int N     = 2,
    parameter int nBits = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    matrix_scan_controller_if.slave bus
);
    localparam int c_TOTAL = M * N;
    localparam int c_KW    = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [nBits-1:0] c_ILAST  = nBits'(M - 1);
    localparam logic [nBits-1:0] c_JLAST  = nBits'(N - 1);
    localparam logic [nBits-1:0] c_ONE    = nBits'(1);
    localparam logic [nBits-1:0] c_ZERO   = '0;
    localparam logic             c_SINGLE = (c_TOTAL == 1);

    logic [1:0]               r_state;
    logic [c_TOTAL*nBits-1:0] r_matrix;
    logic                     r_mode;
    logic                     r_out_valid;
    logic [nBits-1:0]         r_element;
    logic [nBits-1:0]         r_ipos;
    logic [nBits-1:0]         r_jpos;
    logic                     r_out_last;
    logic                     r_busy;
    logic                     r_done;

    logic [1:0]               w_next_state;
    logic [c_TOTAL*nBits-1:0] w_matrix;
    logic                     w_mode;
    logic                     w_out_valid;
    logic [nBits-1:0]         w_element;
    logic [nBits-1:0]         w_ipos;
    logic [nBits-1:0]         w_jpos;
    logic                     w_out_last;
    logic                     w_busy;
    logic                     w_done;

    logic                     w_start_ok;
    logic                     w_xfer;
    logic [nBits-1:0]         w_adv_i;
    logic [nBits-1:0]         w_adv_j;
    logic [c_KW-1:0]          w_k;
    logic [nBits-1:0]         w_elems [c_TOTAL];

    assign w_start_ok = bus.start & ~bus.abort;
    assign w_xfer     = r_out_valid & bus.out_ready;

    // Element k = i*N+j lives at slot (TOTAL-1-k), so (0,0) is the MSB element
    generate
        for (genvar k = 0; k < c_TOTAL; k++) begin : g_unpack
            assign w_elems[k] = r_matrix[(c_TOTAL-1-k)*nBits +: nBits];
        end
    endgenerate

    always_comb begin
        w_adv_i = r_ipos;
        w_adv_j = r_jpos;
        if (!r_mode) begin
            if (r_jpos == c_JLAST) begin
                w_adv_j = c_ZERO;
                w_adv_i = r_ipos + c_ONE;
            end else begin
                w_adv_j = r_jpos + c_ONE;
            end
        end else begin
            if (r_ipos == c_ILAST) begin
                w_adv_i = c_ZERO;
                w_adv_j = r_jpos + c_ONE;
            end else begin
                w_adv_i = r_ipos + c_ONE;
            end
        end
    end

    // Modular arithmetic is exact here because the true index is < 2^c_KW
    assign w_k = c_KW'(w_adv_i) * c_KW'(N) + c_KW'(w_adv_j);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_matrix    <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_element   <= '0;
            r_ipos      <= '0;
            r_jpos      <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_matrix    <= w_matrix;
            r_mode      <= w_mode;
            r_out_valid <= w_out_valid;
            r_element   <= w_element;
            r_ipos      <= w_ipos;
            r_jpos      <= w_jpos;
            r_out_last  <= w_out_last;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_start_ok) w_next_state = c_SCAN;
            c_SCAN: begin
                if (bus.abort)
                    w_next_state = c_IDLE;
                else if (w_xfer && r_out_last)
                    w_next_state = c_DONE;
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_matrix    = r_matrix;
        w_mode      = r_mode;
        w_element   = r_element;
        w_ipos      = r_ipos;
        w_jpos      = r_jpos;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_matrix    = bus.matrix;
                    w_mode      = bus.mode;
                    w_ipos      = c_ZERO;
                    w_jpos      = c_ZERO;
                    w_element   = bus.matrix[c_TOTAL*nBits-1 -: nBits];
                    w_out_last  = c_SINGLE;
                    w_out_valid = 1'b1;
                    w_busy      = 1'b1;
                end
            end
            c_SCAN: begin
                if (bus.abort) begin
                    w_done = 1'b0;
                end else if (w_xfer && r_out_last) begin
                    w_done = 1'b1;
                end else begin
                    w_out_valid = 1'b1;
                    w_busy      = 1'b1;
                    w_out_last  = r_out_last;
                    if (w_xfer) begin
                        w_ipos     = w_adv_i;
                        w_jpos     = w_adv_j;
                        w_element  = w_elems[w_k];
                        w_out_last = (w_adv_i == c_ILAST) && (w_adv_j == c_JLAST);
                    end
                end
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
    end

    assign bus.out_valid = r_out_valid;
    assign bus.element   = r_element;
    assign bus.ipos      = r_ipos;
    assign bus.jpos      = r_jpos;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_controller
// Description : Directed self-checking bench for matrix_scan_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_controller;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matrix_scan_controller_if #(.M(3), .N(2), .nBits(8)) bus ();
    matrix_scan_controller_if #(.M(1), .N(1), .nBits(8)) bus1 ();

    matrix_scan_controller #(.M(3), .N(2), .nBits(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    matrix_scan_controller #(.M(1), .N(1), .nBits(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    localparam logic [47:0] c_MAT  = 48'h01_02_03_04_05_06;
    localparam logic [47:0] c_NINE = 48'h09_09_09_09_09_09;

    int n_checks = 0;
    int n_fail   = 0;

    int row_e [6] = '{1, 2, 3, 4, 5, 6};
    int row_i [6] = '{0, 0, 1, 1, 2, 2};
    int row_j [6] = '{0, 1, 0, 1, 0, 1};
    int col_e [6] = '{1, 3, 5, 2, 4, 6};
    int col_i [6] = '{0, 1, 2, 0, 1, 2};
    int col_j [6] = '{0, 0, 0, 1, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_el(input string tag, input int e, input int i, input int j, input int last);
        chk({tag, ".valid"}, 32'(bus.out_valid), 1);
        chk({tag, ".elem"},  32'(bus.element),   32'(e));
        chk({tag, ".ipos"},  32'(bus.ipos),      32'(i));
        chk({tag, ".jpos"},  32'(bus.jpos),      32'(j));
        chk({tag, ".last"},  32'(bus.out_last),  32'(last));
        chk({tag, ".busy"},  32'(bus.busy),      1);
        chk({tag, ".done"},  32'(bus.done),      0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"},  32'(bus.done),      1);
        chk({tag, ".valid"}, 32'(bus.out_valid), 0);
        chk({tag, ".busy"},  32'(bus.busy),      0);
        chk({tag, ".last"},  32'(bus.out_last),  0);
        tick();
        chk({tag, ".done_low"}, 32'(bus.done), 0);
    endtask

    task automatic start_scan(input logic m);
        bus.start = 1'b1;
        bus.mode  = m;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.abort      = 1'b0;
        bus.matrix     = c_MAT;
        bus.out_ready  = 1'b1;
        bus1.start     = 1'b0;
        bus1.mode      = 1'b0;
        bus1.abort     = 1'b0;
        bus1.matrix    = 8'hA5;
        bus1.out_ready = 1'b1;

        #12;
        chk("rst.valid", 32'(bus.out_valid), 0);
        chk("rst.elem",  32'(bus.element),   0);
        chk("rst.ipos",  32'(bus.ipos),      0);
        chk("rst.jpos",  32'(bus.jpos),      0);
        chk("rst.last",  32'(bus.out_last),  0);
        chk("rst.busy",  32'(bus.busy),      0);
        chk("rst.done",  32'(bus.done),      0);
        tick();
        reset = 1'b0;
        tick();

        // start together with abort must be refused
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa.valid", 32'(bus.out_valid), 0);
        chk("sa.busy",  32'(bus.busy),      0);
        tick();
        chk("sa.valid2", 32'(bus.out_valid), 0);

        start_scan(1'b0);
        for (int k = 0; k < 6; k++) begin
            chk_el($sformatf("row%0d", k), row_e[k], row_i[k], row_j[k], (k == 5) ? 1 : 0);
            tick();
        end
        chk_done("row_end");

        start_scan(1'b1);
        for (int k = 0; k < 6; k++) begin
            chk_el($sformatf("col%0d", k), col_e[k], col_i[k], col_j[k], (k == 5) ? 1 : 0);
            tick();
        end
        chk_done("col_end");

        start_scan(1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_el($sformatf("bp%0d", k), row_e[k], row_i[k], row_j[k], 0);
            if (k < 2) tick();
        end
        bus.out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk_el($sformatf("bp_hold%0d", h), 3, 1, 0, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        for (int k = 3; k < 6; k++) begin
            chk_el($sformatf("bp%0d", k), row_e[k], row_i[k], row_j[k], (k == 5) ? 1 : 0);
            tick();
        end
        chk_done("bp_end");

        start_scan(1'b0);
        chk_el("ign0", 1, 0, 0, 0);
        tick();
        chk_el("ign1", 2, 0, 1, 0);
        bus.start  = 1'b1;
        bus.mode   = 1'b1;
        bus.matrix = c_NINE;
        tick();
        bus.start = 1'b0;
        for (int k = 2; k < 6; k++) begin
            chk_el($sformatf("ign%0d", k), row_e[k], row_i[k], row_j[k], (k == 5) ? 1 : 0);
            tick();
        end
        chk_done("ign_end");
        chk("ign.idle_valid", 32'(bus.out_valid), 0);
        bus.matrix = c_MAT;
        bus.mode   = 1'b0;

        start_scan(1'b0);
        chk_el("ab0", 1, 0, 0, 0);
        tick();
        chk_el("ab1", 2, 0, 1, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab.valid", 32'(bus.out_valid), 0);
        chk("ab.busy",  32'(bus.busy),      0);
        chk("ab.done",  32'(bus.done),      0);
        tick();
        chk("ab.done2",  32'(bus.done),      0);
        chk("ab.valid2", 32'(bus.out_valid), 0);
        start_scan(1'b0);
        chk_el("ab_restart", 1, 0, 0, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("ab2.valid", 32'(bus.out_valid), 0);
        chk("ab2.done",  32'(bus.done),      0);

        start_scan(1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_el($sformatf("ar%0d", k), row_e[k], row_i[k], row_j[k], 0);
            tick();
        end
        chk_el("ar3", 4, 1, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.valid", 32'(bus.out_valid), 0);
        chk("ar.elem",  32'(bus.element),   0);
        chk("ar.ipos",  32'(bus.ipos),      0);
        chk("ar.jpos",  32'(bus.jpos),      0);
        chk("ar.last",  32'(bus.out_last),  0);
        chk("ar.busy",  32'(bus.busy),      0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar.done",   32'(bus.done),      0);
        chk("ar.valid2", 32'(bus.out_valid), 0);
        start_scan(1'b0);
        for (int k = 0; k < 6; k++) begin
            chk_el($sformatf("ars%0d", k), row_e[k], row_i[k], row_j[k], (k == 5) ? 1 : 0);
            tick();
        end
        chk_done("ars_end");

        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk("one.valid", 32'(bus1.out_valid), 1);
        chk("one.elem",  32'(bus1.element),   32'h A5);
        chk("one.ipos",  32'(bus1.ipos),      0);
        chk("one.jpos",  32'(bus1.jpos),      0);
        chk("one.last",  32'(bus1.out_last),  1);
        tick();
        chk("one.done",   32'(bus1.done),      1);
        chk("one.valid2", 32'(bus1.out_valid), 0);
        tick();
        chk("one.done2",  32'(bus1.done),      0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 Parameter M, default 3: matrix row count; the block SHALL support M >= 1 and M <= 2^nBits.
REQ-002 Parameter N, default 2: matrix column count; the block SHALL support N >= 1 and N <= 2^nBits.
REQ-003 Parameter nBits, default 8: element width and index width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle scan request; sampled only in IDLE.
REQ-008 mode  input  1  0 = row-major scan, 1 = column-major scan; sampled with start.
REQ-009 abort  input  1  synchronous scan cancel.
REQ-010 matrix  input  M*N*nBits  packed matrix; sampled with start.
REQ-011 out_ready  input  1  consumer ready.
REQ-012 out_valid  output  1  element, ipos and jpos are valid.
REQ-013 element  output  nBits  selected element (ipos,jpos).
REQ-014 ipos  output  nBits  current row index.
REQ-015 jpos  output  nBits  current column index.
REQ-016 out_last  output  1  current element is the final element of the scan.
REQ-017 busy  output  1  high in SCAN.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 Packing: element(i,j) SHALL occupy bits [((M*N-1)-(i*N+j))*nBits +: nBits], so (0,0) is the most significant element.
REQ-020 FSM states: IDLE, SCAN, DONE. All outputs SHALL be registered.
REQ-021 IDLE with start=1 and abort=0: latch matrix and mode, set ipos=jpos=0, and go to SCAN; out_valid=1 with element(0,0) on the next cycle, for a latency of 1.
REQ-022 IDLE with start=1 and abort=1: abort wins and the state remains IDLE.
REQ-023 start in SCAN or DONE SHALL be ignored, and the latched matrix and mode SHALL be unchanged.
REQ-024 Transfer occurs on a cycle with out_valid=1 and out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, element, ipos, jpos and out_last SHALL hold stable.
REQ-026 Row-major advance on transfer: jpos++; at jpos=N-1, jpos wraps to 0 and ipos++.
REQ-027 Column-major advance on transfer: ipos++; at ipos=M-1, ipos wraps to 0 and jpos++.
REQ-028 out_last SHALL be 1 exactly when (ipos,jpos)=(M-1,N-1), in either mode.
REQ-029 A transfer with out_last=1 SHALL move to DONE: out_valid=0 and done=1 for one cycle, then IDLE.
REQ-030 After a transfer, the next element SHALL be valid on the following cycle, giving back-to-back throughput of 1 element per cycle.
REQ-031 abort in SCAN or DONE SHALL move to IDLE on the next edge: out_valid=0 and busy=0, with no done pulse.
REQ-032 abort coincident with a transfer: the transfer completes, but the scan still aborts and no done pulse is issued.
REQ-033 M=N=1: a single element is presented with out_last=1, then DONE follows.
REQ-034 Changes on matrix during SCAN SHALL NOT affect the output; only the latched copy is used.

Reset
REQ-035 With reset=1, the block SHALL immediately enter IDLE: out_valid, out_last, busy and done = 0; element, ipos and jpos = 0; latched matrix = 0; latched mode = 0.
REQ-036 Reset mid-scan SHALL discard progress without a done pulse; a subsequent start SHALL begin again at (0,0).

Verification (M=3, N=2, nBits=8, matrix={1,2,3,4,5,6})
REQ-037 Row-major, out_ready=1: start, mode=0 -> elements 1,2,3,4,5,6 on 6 consecutive cycles; (ipos,jpos) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1); out_last only on 6; done pulse on the next cycle.
REQ-038 Column-major: start, mode=1 -> elements 1,3,5,2,4,6; (ipos,jpos) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); out_last on 6.
REQ-039 Backpressure: out_ready=0 for 3 cycles while element=3 -> element=3, ipos=1, jpos=0 held stable; sequence resumes at 4 when out_ready=1; still 6 transfers total.
REQ-040 Start ignored and matrix changed: second start with matrix={9,9,9,9,9,9} during SCAN -> original sequence 1..6 unchanged, exactly one done pulse.
REQ-041 Abort: abort after element 2 transfers -> out_valid=0 and busy=0 next cycle, no done pulse; new start outputs 1 first.
REQ-042 Async reset: reset asserted between clock edges at element 4 -> outputs 0 before the next edge; after release, start restarts at element 1.
